score_overlay: RTL

- Renders both players' two-digit scores as on-screen seven-segment glyphs for the Pong VGA path.
- Sits downstream of the VGA timing generator and the game state machine. It consumes the pixel coordinates x/y, blank, vsync and the four score digits.
- Produces a pixel-on flag that the colour stage ORs with ball, paddle and mid-line.
- Scores are latched once per frame so digits never tear. A newly changed score blinks for a fixed number of frames.

---
 rtl/score_overlay.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/score_overlay.sv
// Seven-segment score overlay for the Pong VGA path: per-frame score latching,
// change-triggered blinking and a two-stage pixel pipeline producing overlay_on.
module score_overlay #(
    parameter int DIGIT_W      = 20,
    parameter int DIGIT_H      = 40,
    parameter int SEG_T        = 4,
    parameter int GAP          = 8,
    parameter int TOP_Y        = 16,
    parameter int P1_X         = 240,
    parameter int P2_X         = 360,
    parameter int FLASH_FRAMES = 64
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       blank,
    input  logic       vsync,
    input  logic [3:0] score_1_tens,
    input  logic [3:0] score_1_ones,
    input  logic [3:0] score_2_tens,
    input  logic [3:0] score_2_ones,
    output logic       overlay_on,
    output logic       blank_d
);

    localparam logic [9:0] DW    = 10'(DIGIT_W);
    localparam logic [9:0] TY    = 10'(TOP_Y);
    localparam logic [9:0] BY    = 10'(TOP_Y + DIGIT_H);
    localparam logic [9:0] X1T   = 10'(P1_X);
    localparam logic [9:0] X1O   = 10'(P1_X + DIGIT_W + GAP);
    localparam logic [9:0] X2T   = 10'(P2_X);
    localparam logic [9:0] X2O   = 10'(P2_X + DIGIT_W + GAP);
    localparam logic [9:0] ST    = 10'(SEG_T);
    localparam logic [9:0] XR    = 10'(DIGIT_W - SEG_T);
    localparam logic [9:0] H2    = 10'(DIGIT_H / 2);
    localparam logic [9:0] YD    = 10'(DIGIT_H - SEG_T);
    localparam logic [9:0] GLO   = 10'(DIGIT_H / 2 - SEG_T / 2);
    localparam logic [9:0] GHI   = 10'(DIGIT_H / 2 + SEG_T / 2);
    localparam logic [6:0] FLASH = 7'(FLASH_FRAMES);

    logic       vsync_q, primed, tick;
    logic [3:0] s1t, s1o, s2t, s2o;
    logic [6:0] fc1, fc2;
    logic       ch1, ch2, hide_1, hide_2;

    assign tick   = vsync_q & ~vsync;
    assign ch1    = {score_1_tens, score_1_ones} != {s1t, s1o};
    assign ch2    = {score_2_tens, score_2_ones} != {s2t, s2o};
    assign hide_1 = (fc1 != 7'd0) & fc1[3];
    assign hide_2 = (fc2 != 7'd0) & fc2[3];

    // The first tick after reset only fills the shadows; it must not count as a score change.
    always_ff @(posedge clk25) begin
        if (reset) begin
            vsync_q <= 1'b1;
            primed  <= 1'b0;
            s1t     <= '0;
            s1o     <= '0;
            s2t     <= '0;
            s2o     <= '0;
            fc1     <= '0;
            fc2     <= '0;
        end else begin
            vsync_q <= vsync;
            if (tick) begin
                s1t    <= score_1_tens;
                s1o    <= score_1_ones;
                s2t    <= score_2_tens;
                s2o    <= score_2_ones;
                primed <= 1'b1;
                if (primed && ch1)
                    fc1 <= FLASH;
                else if (fc1 != 7'd0)
                    fc1 <= fc1 - 7'd1;
                if (primed && ch2)
                    fc2 <= FLASH;
                else if (fc2 != 7'd0)
                    fc2 <= fc2 - 7'd1;
            end
        end
    end

    logic       hit_c, pid_c, in_rows;
    logic [3:0] dig_c;
    logic [9:0] bx_c, lx_c, ly_c;

    assign in_rows = (y >= TY) && (y < BY);

    always_comb begin
        hit_c = 1'b0;
        pid_c = 1'b0;
        dig_c = '0;
        bx_c  = '0;
        if (in_rows) begin
            if (x >= X1T && x < X1T + DW) begin
                hit_c = 1'b1;
                dig_c = s1t;
                bx_c  = X1T;
            end else if (x >= X1O && x < X1O + DW) begin
                hit_c = 1'b1;
                dig_c = s1o;
                bx_c  = X1O;
            end else if (x >= X2T && x < X2T + DW) begin
                hit_c = 1'b1;
                pid_c = 1'b1;
                dig_c = s2t;
                bx_c  = X2T;
            end else if (x >= X2O && x < X2O + DW) begin
                hit_c = 1'b1;
                pid_c = 1'b1;
                dig_c = s2o;
                bx_c  = X2O;
            end
        end
        lx_c = hit_c ? x - bx_c : '0;
        ly_c = hit_c ? y - TY : '0;
    end

    logic       hit1, pid1, blank1;
    logic [3:0] dig1;
    logic [9:0] lx1, ly1;

    always_ff @(posedge clk25) begin
        if (reset) begin
            hit1   <= 1'b0;
            pid1   <= 1'b0;
            dig1   <= '0;
            lx1    <= '0;
            ly1    <= '0;
            blank1 <= 1'b1;
        end else begin
            hit1   <= hit_c;
            pid1   <= pid_c;
            dig1   <= dig_c;
            lx1    <= lx_c;
            ly1    <= ly_c;
            blank1 <= blank;
        end
    end

    // Segment order {a,b,c,d,e,f,g}.
    logic [6:0] mask, segs;
    logic       lit, hide;

    always_comb begin
        mask[6] = ly1 < ST;
        mask[5] = (lx1 >= XR) && (ly1 < H2);
        mask[4] = (lx1 >= XR) && (ly1 >= H2);
        mask[3] = ly1 >= YD;
        mask[2] = (lx1 < ST) && (ly1 >= H2);
        mask[1] = (lx1 < ST) && (ly1 < H2);
        mask[0] = (ly1 >= GLO) && (ly1 < GHI);
        case (dig1)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        lit  = |(segs & mask);
        hide = pid1 ? hide_2 : hide_1;
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            overlay_on <= 1'b0;
            blank_d    <= 1'b1;
        end else begin
            overlay_on <= hit1 & ~blank1 & ~hide & lit;
            blank_d    <= blank1;
        end
    end

endmodule
